// File: rtl/cache_victim_seq.sv
// Miss-handling sequencer: optional victim writeback, line fetch, then tag/valid/LRU commit.
// Latency: clean miss BEATS+1 cycles from the latch edge to IDLE, dirty miss 2*BEATS+1; Stall is combinational in IDLE.
// Backpressure: BusReq holds until BusAck; a beat advances only on BusAck without BusErr, BusErr aborts to IDLE.
//
// Ports:
//   clk, reset        - clock and synchronous active-high reset
//   Miss, FlushStage  - current access missed / is being flushed (only looked at in IDLE)
//   VictimWay, VictimDirty, SetIdx - victim selection, latched into SelWay/SelSet when a miss starts
//   BusAck, BusErr    - per-beat handshake from the bus; BusErr only meaningful with BusAck
//   BusReq, BusWrite, BeatCount - beat request, direction (1 = writeback) and beat index
//   SelWay, SelSet    - latched victim way/set that drive the data and tag arrays
//   Stall, SetValid, ClearDirty, LRUWriteEn, Error - pipeline hold, commit strobes, abort pulse
module cache_victim_seq #(
  parameter int NUMWAYS = 4,
  parameter int SETLEN  = 9,
  parameter int BEATS   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     Miss,
  input  logic                     FlushStage,
  input  logic [NUMWAYS-1:0]       VictimWay,
  input  logic                     VictimDirty,
  input  logic [SETLEN-1:0]        SetIdx,
  input  logic                     BusAck,
  input  logic                     BusErr,
  output logic                     BusReq,
  output logic                     BusWrite,
  output logic [$clog2(BEATS)-1:0] BeatCount,
  output logic [NUMWAYS-1:0]       SelWay,
  output logic [SETLEN-1:0]        SelSet,
  output logic                     Stall,
  output logic                     SetValid,
  output logic                     ClearDirty,
  output logic                     LRUWriteEn,
  output logic                     Error
);

  localparam int BW = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRBACK = 2'd1,
    FETCH  = 2'd2,
    COMMIT = 2'd3
  } stateT;

  stateT             state;
  stateT             nextState;
  logic [BW-1:0]     beatQ;
  logic [NUMWAYS-1:0] wayQ;
  logic [SETLEN-1:0] setQ;
  logic              errQ;

  logic start;
  logic inXfer;
  logic beatOk;
  logic busFault;
  logic lastBeat;

  always_comb begin
    start    = (state == IDLE) && Miss && !FlushStage;
    inXfer   = (state == WRBACK) || (state == FETCH);
    beatOk   = inXfer && BusAck && !BusErr;
    busFault = inXfer && BusAck && BusErr;
    lastBeat = (beatQ == BW'(BEATS - 1));
  end

  // Next state. A victim way of all zeros is treated as clean: there is no
  // line to write back, and COMMIT then writes no way.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (start) begin
          nextState = (VictimDirty && (VictimWay != '0)) ? WRBACK : FETCH;
        end
      end
      WRBACK: begin
        if (busFault)              nextState = IDLE;
        else if (beatOk && lastBeat) nextState = FETCH;
      end
      FETCH: begin
        if (busFault)              nextState = IDLE;
        else if (beatOk && lastBeat) nextState = COMMIT;
      end
      COMMIT: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Outputs are forced low while reset is asserted, so nothing leaks out of a
  // state that reset is about to discard.
  always_comb begin
    BusReq     = 1'b0;
    BusWrite   = 1'b0;
    Stall      = 1'b0;
    SetValid   = 1'b0;
    ClearDirty = 1'b0;
    LRUWriteEn = 1'b0;
    Error      = 1'b0;
    if (!reset) begin
      Error = errQ;
      case (state)
        IDLE:   Stall = start;
        WRBACK: begin
          Stall    = 1'b1;
          BusReq   = 1'b1;
          BusWrite = 1'b1;
        end
        FETCH: begin
          Stall  = 1'b1;
          BusReq = 1'b1;
        end
        COMMIT: begin
          Stall      = 1'b1;
          SetValid   = 1'b1;
          ClearDirty = 1'b1;
          LRUWriteEn = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      beatQ <= '0;
      wayQ  <= '0;
      setQ  <= '0;
      errQ  <= 1'b0;
    end else begin
      state <= nextState;
      errQ  <= busFault;
      if (start) begin
        wayQ <= VictimWay;
        setQ <= SetIdx;
      end
      // BEATS is a power of two, so the increment wraps to 0 after the last beat.
      if (busFault) begin
        beatQ <= '0;
      end else if (beatOk) begin
        beatQ <= beatQ + BW'(1);
      end
    end
  end

  assign BeatCount = beatQ;
  assign SelWay    = wayQ;
  assign SelSet    = setQ;

endmodule
